demux_dispatch: RTL

DEMUX_DISPATCH -- requirements
Module: demux_dispatch

---
 rtl/demux_dispatch.sv | 94 +++++++++
 1 files changed

// File: rtl/demux_dispatch.sv
// demux_dispatch: routes one input beat per cycle to one of four channels.
// Each channel is a one-entry buffer (data register + full flag). A beat
// aimed at a full channel whose consumer is not taking its beat this cycle
// is dropped, reported by a one-cycle error pulse and a saturating counter.
//
// Handshake: a channel beat transfers on a rising edge where X_valid=1 and
// X_ready=1; X_ready is ignored while X_valid=0. X_valid only falls after a
// transfer and X never changes while X_valid=1 and X_ready=0.

`ifndef WIDTH
`define WIDTH 8
`endif

module demux_dispatch (
   input  logic              clk,
   input  logic              rst_n,
   input  logic [`WIDTH-1:0] in_data,
   input  logic              in_valid,
   input  logic [1:0]        select,
   output logic [`WIDTH-1:0] A,
   output logic [`WIDTH-1:0] B,
   output logic [`WIDTH-1:0] C,
   output logic [`WIDTH-1:0] D,
   output logic              A_valid,
   output logic              B_valid,
   output logic              C_valid,
   output logic              D_valid,
   input  logic              A_ready,
   input  logic              B_ready,
   input  logic              C_ready,
   input  logic              D_ready,
   output logic              error,
   output logic [3:0]        drop_cnt
);

   logic [`WIDTH-1:0] data_q [4];
   logic [3:0]        full_q;
   logic [3:0]        ready;
   logic [3:0]        pop;
   logic              accept;
   logic              reject;

   assign ready = {D_ready, C_ready, B_ready, A_ready};

   // Pops, accept and reject decisions for the current cycle.
   always_comb begin
      pop    = full_q & ready;
      accept = in_valid & (~full_q[select] | pop[select]);
      reject = in_valid & full_q[select] & ~ready[select];
   end

   // Channel buffers: a same-edge pop and accept keeps the channel full
   // with the new beat, so a streaming channel never shows a bubble.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < 4; i++) begin
            data_q[i] <= '0;
         end
         full_q <= '0;
      end else begin
         for (int i = 0; i < 4; i++) begin
            if (accept && (select == 2'(i))) begin
               data_q[i] <= in_data;
               full_q[i] <= 1'b1;
            end else if (pop[i]) begin
               full_q[i] <= 1'b0;
            end
         end
      end
   end

   // Drop reporting: one error cycle per rejected beat, counter sticks at 15.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         error    <= 1'b0;
         drop_cnt <= 4'd0;
      end else begin
         error <= reject;
         if (reject && (drop_cnt != 4'd15)) begin
            drop_cnt <= drop_cnt + 4'd1;
         end
      end
   end

   assign A       = data_q[0];
   assign B       = data_q[1];
   assign C       = data_q[2];
   assign D       = data_q[3];
   assign A_valid = full_q[0];
   assign B_valid = full_q[1];
   assign C_valid = full_q[2];
   assign D_valid = full_q[3];

endmodule
